// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD execute stage and the decoder that feeds it.
package simd_pkg;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_MUL = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam int LANES     = 4;
  localparam int NREG      = 8;
  localparam int REG_IDX_W = 3;
  localparam int MASK_W    = 4;
endpackage

// File: rtl/simd_lane_alu.sv
// Combinational single-lane ALU; results wrap to DATA_W bits.
module simd_lane_alu
  import simd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e             op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_MUL: y = a * b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/simd_exec.sv
// Two-stage SIMD read / execute-writeback with per-lane forwarding and a host
// load/readback port into the 8 x LANES register file.
module simd_exec
  import simd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [1:0]                op,
  input  logic [MASK_W-1:0]         mask,
  input  logic [REG_IDX_W-1:0]      dest,
  input  logic [REG_IDX_W-1:0]      srcA,
  input  logic [REG_IDX_W-1:0]      srcB,
  input  logic                      ld_en,
  input  logic [REG_IDX_W-1:0]      ld_reg,
  input  logic [1:0]                ld_lane,
  input  logic [DATA_W-1:0]         ld_data,
  input  logic [REG_IDX_W-1:0]      rd_reg,
  output logic [LANES*DATA_W-1:0]   rd_data,
  output logic                      wb_valid,
  output logic [REG_IDX_W-1:0]      wb_dest,
  output logic [MASK_W-1:0]         wb_mask,
  output logic [LANES*DATA_W-1:0]   wb_data
);
  localparam int STAGES = 2;

  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

  typedef struct packed {
    alu_op_e                op;
    logic [MASK_W-1:0]      mask;
    logic [REG_IDX_W-1:0]   dest;
    vec_t                   a;
    vec_t                   b;
  } rd_stage_t;

  vec_t       rf [NREG];
  rd_stage_t  s1;
  logic [STAGES:1] vld_pipe;
  vec_t       fwd_a, fwd_b, ex_y;
  logic       ld_hit;

  // Forward only lanes the EX instruction will actually write; masked-off
  // lanes of the same register still come from the RF.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign fwd_a[i] = (vld_pipe[1] && s1.dest == srcA && s1.mask[i]) ? ex_y[i] : rf[srcA][i];
    assign fwd_b[i] = (vld_pipe[1] && s1.dest == srcB && s1.mask[i]) ? ex_y[i] : rf[srcB][i];

    simd_lane_alu #(.DATA_W(DATA_W)) u_alu (
      .op (s1.op),
      .a  (s1.a[i]),
      .b  (s1.b[i]),
      .y  (ex_y[i])
    );
  end

  // Writeback owns the lane when both target the same register lane.
  assign ld_hit   = vld_pipe[1] && (s1.dest == ld_reg) && s1.mask[ld_lane];
  assign wb_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
      rd_data  <= '0;
      wb_dest  <= '0;
      wb_mask  <= '0;
      wb_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid)
        s1 <= '{op: alu_op_e'(op), mask: mask, dest: dest, a: fwd_a, b: fwd_b};
      rd_data <= rf[rd_reg];
      if (ld_en && !ld_hit)
        rf[ld_reg][ld_lane] <= ld_data;
      if (vld_pipe[1]) begin
        for (int l = 0; l < LANES; l++)
          if (s1.mask[l]) rf[s1.dest][l] <= ex_y[l];
        wb_dest <= s1.dest;
        wb_mask <= s1.mask;
        wb_data <= ex_y;
      end
    end
  end
endmodule

// File: tb/tb_simd_exec.sv
// Self-checking bench for simd_exec: vector table plus hand-written hazard,
// masking, collision and reset sequences, with a retire-order scoreboard.
module tb_simd_exec;
  localparam int DATA_W = 8;

  logic        clk, rst;
  logic        in_valid;
  logic [1:0]  op;
  logic [3:0]  mask;
  logic [2:0]  dest, srcA, srcB;
  logic        ld_en;
  logic [2:0]  ld_reg;
  logic [1:0]  ld_lane;
  logic [7:0]  ld_data;
  logic [2:0]  rd_reg;
  logic [31:0] rd_data;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic [3:0]  wb_mask;
  logic [31:0] wb_data;

  simd_exec #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .mask(mask),
    .dest(dest), .srcA(srcA), .srcB(srcB), .ld_en(ld_en), .ld_reg(ld_reg),
    .ld_lane(ld_lane), .ld_data(ld_data), .rd_reg(rd_reg), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_mask(wb_mask), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  mask;
    logic [2:0]  dest, sa, sb;
    logic [7:0]  va, vb;
    logic [31:0] exp_wb, exp_rf;
  } vec_t;

  typedef struct {
    logic [2:0]  dest;
    logic [3:0]  mask;
    logic [31:0] data;
    int          cyc;
  } wb_t;

  wb_t  sbq[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_mask = '0;
  logic [2:0]  last_dest = '0;
  vec_t tbl[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Retire monitor: order, content, latency, and hold-when-idle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_wb_ctl", {25'b0, wb_dest, wb_mask}, 32'h0);
      chk("rst_rd_data", rd_data, 32'h0);
      last_data = '0; last_mask = '0; last_dest = '0;
    end else if (wb_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wb_unexpected: got retire dest %0d data %h, want none", wb_dest, wb_data);
      end else begin
        wb_t e;
        e = sbq.pop_front();
        chk("wb_dest", {29'b0, wb_dest}, {29'b0, e.dest});
        chk("wb_mask", {28'b0, wb_mask}, {28'b0, e.mask});
        chk("wb_data", wb_data, e.data);
        chk("wb_latency", cyc, e.cyc);
      end
      last_data = wb_data; last_mask = wb_mask; last_dest = wb_dest;
    end else begin
      chk("wb_hold", {wb_data}, last_data);
      chk("wb_hold_ctl", {25'b0, wb_dest, wb_mask}, {25'b0, last_dest, last_mask});
    end
  end

  task automatic idle();
    @(negedge clk); in_valid = 0; ld_en = 0;
  endtask

  task automatic ld(input logic [2:0] r, input logic [1:0] l, input logic [7:0] d);
    @(negedge clk); in_valid = 0; ld_en = 1; ld_reg = r; ld_lane = l; ld_data = d;
  endtask

  task automatic load_all(input logic [2:0] r, input logic [7:0] d);
    for (int l = 0; l < 4; l++) ld(r, l[1:0], d);
  endtask

  task automatic issue(input logic [1:0] o, input logic [3:0] m, input logic [2:0] d,
                       input logic [2:0] a, input logic [2:0] b, input logic [31:0] exp,
                       input bit push);
    @(negedge clk);
    ld_en = 0; in_valid = 1; op = o; mask = m; dest = d; srcA = a; srcB = b;
    if (push) sbq.push_back('{dest: d, mask: m, data: exp, cyc: cyc + 2});
  endtask

  task automatic rd_check(input string nm, input logic [2:0] r, input logic [31:0] exp);
    @(negedge clk); in_valid = 0; ld_en = 0; rd_reg = r;
    @(negedge clk); chk(nm, rd_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 0; op = 0; mask = 0; dest = 0; srcA = 0; srcB = 0;
    ld_en = 0; ld_reg = 0; ld_lane = 0; ld_data = 0; rd_reg = 0; rst = 0;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    #2 rst = 0;

    //          op     mask     dst sa sb  va     vb     exp_wb        exp_rf
    tbl[0] = '{2'b00, 4'b1111, 0, 1, 2, 8'h03, 8'h05, 32'h08080808, 32'h08080808};
    tbl[1] = '{2'b01, 4'b1111, 1, 0, 3, 8'h20, 8'h10, 32'h00000000, 32'h00000000};
    tbl[2] = '{2'b01, 4'b1111, 1, 0, 3, 8'h0F, 8'h11, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[3] = '{2'b10, 4'b1111, 4, 5, 6, 8'hF0, 8'h3C, 32'h30303030, 32'h30303030};
    tbl[4] = '{2'b11, 4'b1111, 7, 5, 6, 8'hF0, 8'h0C, 32'hFCFCFCFC, 32'hFCFCFCFC};
    tbl[5] = '{2'b00, 4'b1111, 2, 3, 4, 8'hFF, 8'h02, 32'h01010101, 32'h01010101};

    rd_check("rst_rf_r0", 3'd0, 32'h0);

    for (int i = 0; i < 6; i++) begin
      load_all(tbl[i].sa, tbl[i].va);
      load_all(tbl[i].sb, tbl[i].vb);
      issue(tbl[i].op, tbl[i].mask, tbl[i].dest, tbl[i].sa, tbl[i].sb, tbl[i].exp_wb, 1);
      idle(); idle();
      rd_check("tbl_rf", tbl[i].dest, tbl[i].exp_rf);
    end

    // Partial mask: upper two lanes take the AND result, lower two untouched.
    load_all(3'd2, 8'hAA); load_all(3'd3, 8'h0F); load_all(3'd1, 8'hFF);
    issue(2'b10, 4'b1100, 3'd2, 3'd3, 3'd1, 32'h0F0F0F0F, 1);
    idle(); idle();
    rd_check("mask_rf_r2", 3'd2, 32'h0F0FAAAA);

    // Back-to-back RAW through the forwarding path.
    load_all(3'd1, 8'h03); load_all(3'd2, 8'h05); load_all(3'd3, 8'h02);
    issue(2'b00, 4'b1111, 3'd0, 3'd1, 3'd2, 32'h08080808, 1);
    issue(2'b01, 4'b1111, 3'd1, 3'd0, 3'd3, 32'h10101010, 1);
    idle(); idle();
    rd_check("raw_rf_r1", 3'd1, 32'h10101010);
    rd_check("raw_rf_r0", 3'd0, 32'h08080808);

    // All-zero NOP: retires with r0+r0 but writes nothing.
    issue(2'b00, 4'b0000, 3'd0, 3'd0, 3'd0, 32'h10101010, 1);
    idle(); idle();
    rd_check("nop_rf_r0", 3'd0, 32'h08080808);

    // Host write colliding with writeback lane: writeback wins.
    issue(2'b00, 4'b0001, 3'd0, 3'd1, 3'd2, 32'h15151515, 1);
    @(negedge clk); in_valid = 0; ld_en = 1; ld_reg = 3'd0; ld_lane = 2'd0; ld_data = 8'h77;
    idle(); idle();
    rd_check("collide_rf_r0", 3'd0, 32'h08080815);

    // Host write to a different lane of the same register: both land.
    issue(2'b00, 4'b0001, 3'd0, 3'd1, 3'd2, 32'h15151515, 1);
    @(negedge clk); in_valid = 0; ld_en = 1; ld_reg = 3'd0; ld_lane = 2'd3; ld_data = 8'h99;
    idle(); idle();
    rd_check("nocollide_rf_r0", 3'd0, 32'h99080815);

    // Reset with an instruction in flight: discarded, RF cleared.
    issue(2'b00, 4'b1111, 3'd0, 3'd1, 3'd2, 32'h0, 0);
    @(posedge clk); #2 rst = 1; in_valid = 0;
    @(negedge clk);
    @(negedge clk); #2 rst = 0;
    for (int r = 0; r < 8; r++) rd_check("post_rst_rf", r[2:0], 32'h0);

    load_all(3'd1, 8'h03); load_all(3'd2, 8'h05);
    issue(2'b00, 4'b1111, 3'd0, 3'd1, 3'd2, 32'h08080808, 1);
    idle(); idle();
    rd_check("post_rst_add", 3'd0, 32'h08080808);

    repeat (3) idle();
    chk("sb_drained", sbq.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
